// File: rtl/lcd_sequencer.sv
// Command scheduler for the LCD character core: request FIFO, automatic power-on init, cursor tracking.
// Optional line auto-wrap is enabled by defining LCD_SEQ_AUTOWRAP_EN.
module lcd_sequencer #(
    parameter logic [15:0] CORE_ADDR  = 16'h0016,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LINE_LEN   = 16
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_cmd,
    input  logic [7:0]  wr_data,
    output logic        full,
    output logic        empty,
    output logic        ovf,
    output logic        busy,
    output logic        init_done,
    output logic [4:0]  col,
    output logic        line,
    output logic        lcd_en,
    output logic [15:0] lcd_addr,
    output logic [15:0] lcd_data,
    output logic [2:0]  lcd_cmd,
    input  logic        lcd_done
);

    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [4:0]  LINE_END = 5'(LINE_LEN);

    localparam logic [2:0] CMD_INIT  = 3'd1;
    localparam logic [2:0] CMD_SEND  = 3'd2;
    localparam logic [2:0] CMD_LINE2 = 3'd3;
    localparam logic [2:0] CMD_HOME  = 3'd4;
    localparam logic [2:0] CMD_CLEAR = 3'd6;

    typedef struct packed {
        logic [2:0] cmd;
        logic [7:0] data;
    } req_t;

    typedef enum logic [2:0] {
        S_INIT_ISSUE = 3'd0,
        S_INIT_WAIT  = 3'd1,
        S_IDLE       = 3'd2,
        S_ISSUE      = 3'd3,
        S_WAIT       = 3'd4,
        S_GAP        = 3'd5,
        S_WRAP_CHK   = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic           gap_cnt_q, gap_cnt_d;

    req_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0] wptr_q, wptr_d;
    logic [PTR_W:0] rptr_q, rptr_d;
    logic           full_q, full_d;
    logic           empty_q, empty_d;
    logic           ovf_q, ovf_d;
    logic           push_c;
    logic           pop_c;
    req_t           head_c;
    logic           head_valid_c;

    logic           busy_q, busy_d;
    logic           init_done_q, init_done_d;
    logic [4:0]     col_q, col_d;
    logic           line_q, line_d;
    logic           wrap_pend_q, wrap_pend_d;
    logic           lcd_en_q, lcd_en_d;
    logic [15:0]    lcd_addr_q, lcd_addr_d;
    logic [15:0]    lcd_data_q, lcd_data_d;
    logic [2:0]     lcd_cmd_q, lcd_cmd_d;

    // FIFO bookkeeping; a push while full is dropped regardless of a same-cycle pop
    assign push_c       = wr_en && !full_q;
    assign head_c       = fifo_mem[rptr_q[PTR_W-1:0]];
    assign head_valid_c = (head_c.cmd != 3'd0) && (head_c.cmd != 3'd7);
    assign wptr_d       = wptr_q + {{PTR_W{1'b0}}, push_c};
    assign rptr_d       = rptr_q + {{PTR_W{1'b0}}, pop_c};
    assign full_d       = (wptr_d[PTR_W] != rptr_d[PTR_W]) &&
                          (wptr_d[PTR_W-1:0] == rptr_d[PTR_W-1:0]);
    assign empty_d      = (wptr_d == rptr_d);
    assign ovf_d        = ovf_q || (wr_en && full_q);

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wptr_q[PTR_W-1:0]] <= {wr_cmd, wr_data};
        end
    end

    // State register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_INIT_ISSUE;
            gap_cnt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic; the FIFO is popped only from IDLE once init has completed
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        pop_c     = 1'b0;
        case (state_q)
            S_INIT_ISSUE: state_d = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (lcd_done) begin
                    state_d   = S_GAP;
                    gap_cnt_d = 1'b0;
                end
            end
            S_IDLE: begin
                if (!empty_q && init_done_q) begin
                    pop_c = 1'b1;
                    if (head_valid_c) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (lcd_done) begin
                    state_d   = S_GAP;
                    gap_cnt_d = 1'b0;
                end
            end
            S_GAP: begin
                if (gap_cnt_q) begin
                    state_d   = S_WRAP_CHK;
                    gap_cnt_d = 1'b0;
                end else begin
                    gap_cnt_d = 1'b1;
                end
            end
            S_WRAP_CHK: state_d = wrap_pend_q ? S_ISSUE : S_IDLE;
            default:    state_d = S_INIT_ISSUE;
        endcase
    end

    // Output / datapath next values, registered below
    always_comb begin
        lcd_en_d    = lcd_en_q;
        lcd_addr_d  = lcd_addr_q;
        lcd_data_d  = lcd_data_q;
        lcd_cmd_d   = lcd_cmd_q;
        init_done_d = init_done_q;
        col_d       = col_q;
        line_d      = line_q;
        wrap_pend_d = wrap_pend_q;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_INIT_ISSUE: begin
                lcd_en_d   = 1'b1;
                lcd_addr_d = CORE_ADDR;
                lcd_cmd_d  = CMD_INIT;
                lcd_data_d = 16'h0000;
            end
            S_INIT_WAIT: begin
                if (lcd_done) begin
                    lcd_en_d    = 1'b0;
                    lcd_addr_d  = 16'h0000;
                    init_done_d = 1'b1;
                    col_d       = 5'd0;
                    line_d      = 1'b0;
                end
            end
            S_IDLE: begin
                if (pop_c && head_valid_c) begin
                    lcd_cmd_d  = head_c.cmd;
                    lcd_data_d = {8'h00, head_c.data};
                end
            end
            S_ISSUE: begin
                lcd_en_d   = 1'b1;
                lcd_addr_d = CORE_ADDR;
            end
            S_WAIT: begin
                if (lcd_done) begin
                    lcd_en_d   = 1'b0;
                    lcd_addr_d = 16'h0000;
                    case (lcd_cmd_q)
                        CMD_SEND: begin
                            col_d = (col_q >= LINE_END) ? LINE_END : col_q + 5'd1;
`ifdef LCD_SEQ_AUTOWRAP_EN
                            if (col_q + 5'd1 == LINE_END) begin
                                wrap_pend_d = 1'b1;
                            end
`endif
                        end
                        CMD_LINE2: begin
                            line_d = 1'b1;
                            col_d  = 5'd0;
                        end
                        CMD_INIT, CMD_HOME, CMD_CLEAR: begin
                            line_d = 1'b0;
                            col_d  = 5'd0;
                        end
                        default: ;
                    endcase
                end
            end
            S_WRAP_CHK: begin
                if (wrap_pend_q) begin
                    wrap_pend_d = 1'b0;
                    lcd_cmd_d   = line_q ? CMD_HOME : CMD_LINE2;
                    lcd_data_d  = 16'h0000;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs, FIFO pointers and cursor
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b1;
            init_done_q <= 1'b0;
            col_q       <= 5'd0;
            line_q      <= 1'b0;
            wrap_pend_q <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_addr_q  <= 16'h0000;
            lcd_data_q  <= 16'h0000;
            lcd_cmd_q   <= 3'd0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            col_q       <= col_d;
            line_q      <= line_d;
            wrap_pend_q <= wrap_pend_d;
            lcd_en_q    <= lcd_en_d;
            lcd_addr_q  <= lcd_addr_d;
            lcd_data_q  <= lcd_data_d;
            lcd_cmd_q   <= lcd_cmd_d;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;
    assign init_done = init_done_q;
    assign col       = col_q;
    assign line      = line_q;
    assign lcd_en    = lcd_en_q;
    assign lcd_addr  = lcd_addr_q;
    assign lcd_data  = lcd_data_q;
    assign lcd_cmd   = lcd_cmd_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: LCD core responder, issue monitor and a queue-based
// reference model of the issued command stream and cursor.
module tb_lcd_sequencer;

    localparam int unsigned LINE_LEN  = 16;
    localparam logic [15:0] CORE_ADDR = 16'h0016;

    logic        clk;
    logic        Reset;
    logic        wr_en;
    logic [2:0]  wr_cmd;
    logic [7:0]  wr_data;
    logic        full, empty, ovf, busy, init_done, line, lcd_en, lcd_done;
    logic [4:0]  col;
    logic [15:0] lcd_addr, lcd_data;
    logic [2:0]  lcd_cmd;

    lcd_sequencer dut (
        .clk(clk), .Reset(Reset), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_data(wr_data),
        .full(full), .empty(empty), .ovf(ovf), .busy(busy), .init_done(init_done),
        .col(col), .line(line), .lcd_en(lcd_en), .lcd_addr(lcd_addr), .lcd_data(lcd_data),
        .lcd_cmd(lcd_cmd), .lcd_done(lcd_done)
    );

    int n_vec = 0;
    int n_mis = 0;
    int cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core responder: raises isDone done_dly cycles after en, holds it until en drops
    int   done_dly = 10;
    logic stall    = 1'b0;
    int   dcnt     = 0;
    always @(negedge clk or negedge Reset) begin
        if (!Reset) begin
            lcd_done = 1'b0;
            dcnt     = 0;
        end else if (lcd_en && !stall) begin
            dcnt = dcnt + 1;
            if (dcnt >= done_dly) lcd_done = 1'b1;
        end else if (!lcd_en) begin
            lcd_done = 1'b0;
            dcnt     = 0;
        end
    end

    // Issue monitor
    logic [2:0]  iss_cmd[$];
    logic [15:0] iss_data[$];
    logic [15:0] iss_addr[$];
    int          gaps[$];
    int          last_fall = 0;
    logic        en_prev   = 1'b0;
    always @(negedge clk) begin
        if (lcd_en && !en_prev) begin
            iss_cmd.push_back(lcd_cmd);
            iss_data.push_back(lcd_data);
            iss_addr.push_back(lcd_addr);
            gaps.push_back(cyc - last_fall);
        end
        if (!lcd_en && en_prev) last_fall = cyc;
        en_prev = lcd_en;
    end

    // Reference model: expected issue stream and cursor
    logic [2:0] exp_cmd[$];
    logic [7:0] exp_data[$];
    int         mcol  = 0;
    int         mline = 0;

    task automatic model_accept(input logic [2:0] c, input logic [7:0] d);
        if (c == 3'd0 || c == 3'd7) return;
        exp_cmd.push_back(c);
        exp_data.push_back(d);
        case (c)
            3'd2: begin
                if (mcol < LINE_LEN) mcol = mcol + 1;
`ifdef LCD_SEQ_AUTOWRAP_EN
                if (mcol == LINE_LEN) begin
                    exp_cmd.push_back((mline == 1) ? 3'd4 : 3'd3);
                    exp_data.push_back(8'h00);
                    mline = (mline == 1) ? 0 : 1;
                    mcol  = 0;
                end
`endif
            end
            3'd3:             begin mline = 1; mcol = 0; end
            3'd1, 3'd4, 3'd6: begin mline = 0; mcol = 0; end
            default: ;
        endcase
    endtask

    task automatic clear_logs();
        iss_cmd.delete(); iss_data.delete(); iss_addr.delete(); gaps.delete();
        exp_cmd.delete(); exp_data.delete();
    endtask

    function automatic int issue_diff();
        int n;
        n = (iss_cmd.size() < exp_cmd.size()) ? iss_cmd.size() : exp_cmd.size();
        for (int i = 0; i < n; i++) begin
            if (iss_cmd[i] !== exp_cmd[i] || iss_addr[i] !== CORE_ADDR || iss_data[i][15:8] !== 8'h00 ||
                (exp_cmd[i] == 3'd2 && iss_data[i][7:0] !== exp_data[i]))
                return i;
        end
        if (iss_cmd.size() != exp_cmd.size()) return n;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [2:0] c, input logic [7:0] d);
        int k = 0;
        while (full && k < 3000) begin tick(); k++; end
        n_vec++;
        if (full !== 1'b0) begin
            $display("FAIL push_wait: full=%b, required 0", full);
            n_mis++;
        end
        wr_en = 1'b1; wr_cmd = c; wr_data = d;
        tick();
        wr_en = 1'b0;
        model_accept(c, d);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (!(busy === 1'b0 && empty === 1'b1 && lcd_en === 1'b0) && k < budget) begin tick(); k++; end
        n_vec++;
        if (!(busy === 1'b0 && empty === 1'b1 && lcd_en === 1'b0)) begin
            $display("FAIL idle_timeout: busy=%b empty=%b lcd_en=%b, required 0/1/0", busy, empty, lcd_en);
            n_mis++;
        end
    endtask

    task automatic wait_en(input int budget);
        int k = 0;
        while (lcd_en !== 1'b1 && k < budget) begin tick(); k++; end
        n_vec++;
        if (lcd_en !== 1'b1) begin
            $display("FAIL en_timeout: lcd_en=%b, required 1", lcd_en);
            n_mis++;
        end
    endtask

    task automatic test_reset();
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({lcd_en, lcd_addr, lcd_data, lcd_cmd} !== 36'h0) begin
            $display("FAIL reset_lcd: en=%b addr=%h data=%h cmd=%0d, required all 0", lcd_en, lcd_addr, lcd_data, lcd_cmd);
            n_mis++;
        end
        n_vec++;
        if ({full, empty, ovf, busy, init_done, col, line} !== {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0}) begin
            $display("FAIL reset_flags: full=%b empty=%b ovf=%b busy=%b init_done=%b col=%0d line=%b, required 0 1 0 1 0 0 0",
                     full, empty, ovf, busy, init_done, col, line);
            n_mis++;
        end
        Reset = 1'b1;
        tick();
        n_vec++;
        if (lcd_en !== 1'b1 || lcd_cmd !== 3'd1 || lcd_addr !== CORE_ADDR) begin
            $display("FAIL reset_release: en=%b cmd=%0d addr=%h, required 1 1 %h", lcd_en, lcd_cmd, lcd_addr, CORE_ADDR);
            n_mis++;
        end
    endtask

    task automatic test_init();
        int k = 0;
        while (init_done !== 1'b1 && k < 200) begin tick(); k++; end
        n_vec++;
        if (init_done !== 1'b1) begin
            $display("FAIL init_done: got %b, required 1", init_done);
            n_mis++;
        end
        n_vec++;
        if (lcd_en !== 1'b0) begin $display("FAIL init_gap0: lcd_en=%b, required 0", lcd_en); n_mis++; end
        tick();
        n_vec++;
        if (lcd_en !== 1'b0) begin $display("FAIL init_gap1: lcd_en=%b, required 0", lcd_en); n_mis++; end
        repeat (3) tick();
        n_vec++;
        if (busy !== 1'b0) begin $display("FAIL init_busy: busy=%b, required 0", busy); n_mis++; end
        n_vec++;
        if (iss_cmd.size() != 1 || iss_cmd[0] !== 3'd1) begin
            $display("FAIL init_issues: count=%0d, required exactly one INIT", iss_cmd.size());
            n_mis++;
        end
        n_vec++;
        if (col !== 5'd0 || line !== 1'b0) begin
            $display("FAIL init_cursor: col=%0d line=%b, required 0 0", col, line);
            n_mis++;
        end
        clear_logs();
        mcol = 0; mline = 0;
    endtask

    task automatic test_single();
        clear_logs();
        wr_en = 1'b1; wr_cmd = 3'd2; wr_data = 8'h41;
        model_accept(3'd2, 8'h41);
        tick();
        wr_en = 1'b0;
        n_vec++;
        if (empty !== 1'b0) begin $display("FAIL single_empty: empty=%b, required 0", empty); n_mis++; end
        tick();
        n_vec++;
        if (lcd_en !== 1'b0) begin $display("FAIL single_early: lcd_en=%b, required 0", lcd_en); n_mis++; end
        tick();
        n_vec++;
        if (lcd_en !== 1'b1 || lcd_cmd !== 3'd2 || lcd_data !== 16'h0041 || lcd_addr !== CORE_ADDR) begin
            $display("FAIL single_issue: en=%b cmd=%0d data=%h addr=%h, required 1 2 0041 %h",
                     lcd_en, lcd_cmd, lcd_data, lcd_addr, CORE_ADDR);
            n_mis++;
        end
        wait_idle(200);
        n_vec++;
        if (col !== 5'd1 || line !== 1'b0) begin
            $display("FAIL single_cursor: col=%0d line=%b, required 1 0", col, line);
            n_mis++;
        end
    endtask

    task automatic test_overflow();
        logic [2:0] c;
        logic [7:0] d;
        clear_logs();
        stall = 1'b1;
        push_req(3'd6, 8'h00);
        wait_en(50);
        for (int i = 0; i < 9; i++) begin
            c = 3'($urandom_range(1, 6));
            d = 8'($urandom);
            wr_en = 1'b1; wr_cmd = c; wr_data = d;
            if (i < 8) model_accept(c, d);
            tick();
            if (i == 6) begin
                n_vec++;
                if (full !== 1'b0) begin $display("FAIL ovf_full7: full=%b, required 0", full); n_mis++; end
            end
            if (i == 7) begin
                n_vec++;
                if (full !== 1'b1 || ovf !== 1'b0) begin
                    $display("FAIL ovf_full8: full=%b ovf=%b, required 1 0", full, ovf);
                    n_mis++;
                end
            end
        end
        wr_en = 1'b0;
        n_vec++;
        if (ovf !== 1'b1 || full !== 1'b1) begin
            $display("FAIL ovf_set: ovf=%b full=%b, required 1 1", ovf, full);
            n_mis++;
        end
        stall = 1'b0;
        wait_idle(3000);
        n_vec++;
        if (issue_diff() != -1) begin
            $display("FAIL ovf_order: first diff at %0d, issued=%0d required=%0d", issue_diff(), iss_cmd.size(), exp_cmd.size());
            n_mis++;
        end
        n_vec++;
        if (ovf !== 1'b1 || col !== 5'(mcol) || line !== 1'(mline)) begin
            $display("FAIL ovf_after: ovf=%b col=%0d line=%b, required 1 %0d %0d", ovf, col, line, mcol, mline);
            n_mis++;
        end
    endtask

    task automatic test_wrap();
        int exp_c, exp_l, n_line2;
        clear_logs();
        push_req(3'd6, 8'h00);
        for (int i = 0; i < 17; i++) push_req(3'd2, 8'(8'h30 + i));
        wait_idle(5000);
`ifdef LCD_SEQ_AUTOWRAP_EN
        exp_c = 1; exp_l = 1;
`else
        exp_c = 16; exp_l = 0;
`endif
        n_line2 = 0;
        foreach (iss_cmd[i]) if (iss_cmd[i] == 3'd3) n_line2++;
        n_vec++;
        if (col !== 5'(exp_c) || line !== 1'(exp_l)) begin
            $display("FAIL wrap_cursor: col=%0d line=%b, required %0d %0d", col, line, exp_c, exp_l);
            n_mis++;
        end
        n_vec++;
        if (n_line2 != exp_l) begin
            $display("FAIL wrap_line2: LINE_2 issues=%0d, required %0d", n_line2, exp_l);
            n_mis++;
        end
        n_vec++;
        if (issue_diff() != -1) begin
            $display("FAIL wrap_order: first diff at %0d, issued=%0d required=%0d", issue_diff(), iss_cmd.size(), exp_cmd.size());
            n_mis++;
        end
    endtask

    task automatic test_invalid();
        int n_clear;
        clear_logs();
        push_req(3'd6, 8'h00);
        push_req(3'd0, 8'h55);
        push_req(3'd7, 8'haa);
        push_req(3'd6, 8'h00);
        wait_idle(500);
        n_clear = 0;
        foreach (iss_cmd[i]) if (iss_cmd[i] == 3'd6) n_clear++;
        n_vec++;
        if (n_clear != 2 || iss_cmd.size() != 2) begin
            $display("FAIL invalid_count: clears=%0d issues=%0d, required 2 2", n_clear, iss_cmd.size());
            n_mis++;
        end
        n_vec++;
        if (empty !== 1'b1) begin $display("FAIL invalid_empty: empty=%b, required 1", empty); n_mis++; end
        mcol = 0; mline = 0;
    endtask

    task automatic test_back_to_back();
        clear_logs();
        done_dly = 2;
        stall = 1'b1;
        push_req(3'd6, 8'h00);
        wait_en(50);
        push_req(3'd4, 8'h00);
        push_req(3'd5, 8'h00);
        stall = 1'b0;
        wait_idle(500);
        n_vec++;
        if (issue_diff() != -1) begin
            $display("FAIL b2b_order: first diff at %0d, issued=%0d required=%0d", issue_diff(), iss_cmd.size(), exp_cmd.size());
            n_mis++;
        end
        // done-drop edge E: GAP E..E+1, WRAP_CHK E+2, IDLE E+3, pop E+4, en E+5
        for (int i = 1; i < 3; i++) begin
            n_vec++;
            if (gaps.size() != 3 || gaps[i] != 5) begin
                $display("FAIL b2b_gap%0d: gap=%0d edges (entries %0d), required 5", i,
                         (gaps.size() > i) ? gaps[i] : -1, gaps.size());
                n_mis++;
            end
        end
    endtask

    task automatic test_random();
        int burst;
        for (int b = 0; b < 6; b++) begin
            clear_logs();
            done_dly = $urandom_range(1, 8);
            burst = $urandom_range(3, 12);
            for (int i = 0; i < burst; i++) begin
                push_req(3'($urandom_range(0, 7)), 8'($urandom));
                repeat ($urandom_range(0, 3)) tick();
            end
            wait_idle(3000);
            n_vec++;
            if (issue_diff() != -1) begin
                $display("FAIL rand_order b%0d: first diff at %0d, issued=%0d required=%0d",
                         b, issue_diff(), iss_cmd.size(), exp_cmd.size());
                n_mis++;
            end
            n_vec++;
            if (col !== 5'(mcol) || line !== 1'(mline)) begin
                $display("FAIL rand_cursor b%0d: col=%0d line=%b, required %0d %0d", b, col, line, mcol, mline);
                n_mis++;
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        done_dly = 10;
        stall = 1'b1;
        push_req(3'd6, 8'h00);
        wait_en(50);
        push_req(3'd4, 8'h00);
        push_req(3'd2, 8'h42);
        #2 Reset = 1'b0;
        #1;
        n_vec++;
        if (lcd_en !== 1'b0) begin $display("FAIL mid_en: lcd_en=%b, required 0", lcd_en); n_mis++; end
        n_vec++;
        if (empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0 || init_done !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL mid_flags: empty=%b full=%b ovf=%b init_done=%b busy=%b, required 1 0 0 0 1",
                     empty, full, ovf, init_done, busy);
            n_mis++;
        end
        stall = 1'b0;
        tick();
        clear_logs();
        mcol = 0; mline = 0;
        Reset = 1'b1;
        tick();
        n_vec++;
        if (lcd_en !== 1'b1 || lcd_cmd !== 3'd1) begin
            $display("FAIL mid_reinit: en=%b cmd=%0d, required 1 1", lcd_en, lcd_cmd);
            n_mis++;
        end
        wait_idle(300);
        n_vec++;
        if (init_done !== 1'b1 || iss_cmd.size() != 1) begin
            $display("FAIL mid_after: init_done=%b issues=%0d, required 1 1", init_done, iss_cmd.size());
            n_mis++;
        end
    endtask

    initial begin
        Reset = 1'b0; wr_en = 1'b0; wr_cmd = 3'd0; wr_data = 8'h00;
        test_reset();
        test_init();
        test_single();
        test_overflow();
        test_wrap();
        test_invalid();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
